// File: rtl/rvb_issue.sv
// Issue/decode stage in front of the bit-manipulation ALU: decodes and legality-checks
// each instruction, buffers it in a 2-entry registered FIFO and keeps hand-off statistics.
module rvb_issue #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_rs3,
  output logic            out_insn3,
  output logic            out_insn5,
  output logic            out_insn12,
  output logic            out_insn13,
  output logic            out_insn14,
  output logic            out_insn25,
  output logic            out_insn26,
  output logic            out_insn27,
  output logic            out_insn30,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal,
  output logic [15:0]     cnt_issued,
  output logic [15:0]     cnt_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [8:0]      b;
    logic [TAGW-1:0] tag;
    logic            ill;
  } entry_t;

  localparam logic IS_RV64 = (XLEN == 64);

  entry_t      slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] cnt_issued_q, cnt_issued_d, cnt_illegal_q, cnt_illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [8:0]  dec_b;
  logic        hi_zero, op_b_hit, w_b_hit;
  logic        op_legal, cm_legal, w_legal, addiwu;
  entry_t      new_entry;
  logic        push, pop;
  logic [1:0]  remaining;

  // Register-specifier fields are not needed by the ALU.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{in_insn[19:15], in_insn[11:7]};

  always_comb begin
    opcode   = in_insn[6:0];
    funct3   = in_insn[14:12];
    dec_b    = {in_insn[30], in_insn[27], in_insn[26], in_insn[25],
                in_insn[14:12], in_insn[5], in_insn[3]};
    hi_zero  = !in_insn[31] && !in_insn[29] && !in_insn[28];
    op_b_hit = 1'b0;
    w_b_hit  = 1'b0;
    case (dec_b)
      9'b010110010, 9'b010110110, 9'b010111010, 9'b010111110,
      9'b100011110, 9'b100011010, 9'b100010010, 9'b010010010,
      9'b010011110, 9'b110010010, 9'b000000110, 9'b000001010,
      9'b000001110: op_b_hit = 1'b1;
      default:      op_b_hit = 1'b0;
    endcase
    case (dec_b)
      9'b010010011, 9'b110010011, 9'b010100011, 9'b110100011,
      9'b010000011, 9'b110000011, 9'b000000111, 9'b000001011,
      9'b000001111: w_b_hit = 1'b1;
      default:      w_b_hit = 1'b0;
    endcase

    op_legal = (opcode == 7'b0110011) && !in_insn[26] && hi_zero && op_b_hit;
    // CMIX/CMOV use bits 31:27 for rs3, so no upper-bit constraint applies.
    cm_legal = (opcode == 7'b0110011) && in_insn[26] && in_insn[25] && (funct3[1:0] == 2'b01);
    w_legal  = IS_RV64 && (opcode == 7'b0111011) && hi_zero && w_b_hit;
    addiwu   = IS_RV64 && (opcode == 7'b0011011) && (funct3 == 3'b100);

    new_entry.rs1 = in_rs1;
    new_entry.rs2 = addiwu ? {{(XLEN-12){in_insn[31]}}, in_insn[31:20]} : in_rs2;
    new_entry.rs3 = in_rs3;
    new_entry.b   = dec_b;
    new_entry.tag = in_tag;
    new_entry.ill = !(op_legal || cm_legal || w_legal || addiwu);
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    count_d       = count_q;
    cnt_issued_d  = cnt_issued_q;
    cnt_illegal_d = cnt_illegal_q;
    remaining     = count_q - {1'b0, pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        slot0_d = slot1_q;
        if (slot0_q.ill) begin
          cnt_illegal_d = (cnt_illegal_q == 16'hFFFF) ? cnt_illegal_q : cnt_illegal_q + 16'd1;
        end else begin
          cnt_issued_d = (cnt_issued_q == 16'hFFFF) ? cnt_issued_q : cnt_issued_q + 16'd1;
        end
      end
      // New entry lands in the first slot left free after any pop.
      if (push) begin
        if (remaining == 2'd0) slot0_d = new_entry;
        else                   slot1_d = new_entry;
      end
      count_d = remaining + {1'b0, push};
    end
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot0_q       <= '0;
      slot1_q       <= '0;
      count_q       <= 2'd0;
      in_ready_q    <= 1'b1;
      cnt_issued_q  <= 16'd0;
      cnt_illegal_q <= 16'd0;
    end else begin
      slot0_q       <= slot0_d;
      slot1_q       <= slot1_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      cnt_issued_q  <= cnt_issued_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_rs1     = slot0_q.rs1;
  assign out_rs2     = slot0_q.rs2;
  assign out_rs3     = slot0_q.rs3;
  assign out_insn30  = slot0_q.b[8];
  assign out_insn27  = slot0_q.b[7];
  assign out_insn26  = slot0_q.b[6];
  assign out_insn25  = slot0_q.b[5];
  assign out_insn14  = slot0_q.b[4];
  assign out_insn13  = slot0_q.b[3];
  assign out_insn12  = slot0_q.b[2];
  assign out_insn5   = slot0_q.b[1];
  assign out_insn3   = slot0_q.b[0];
  assign out_tag     = slot0_q.tag;
  assign out_illegal = slot0_q.ill;
  assign cnt_issued  = cnt_issued_q;
  assign cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_rvb_issue.sv
// Bench for rvb_issue: directed scenarios plus random traffic checked against a
// queue-based reference model that decodes straight from the legality rules.
module tb_rvb_issue;
  localparam int XLEN = 64;
  localparam int TAGW = 4;

  logic              clock, resetn, flush, in_valid, out_ready;
  logic [31:0]       in_insn;
  logic [XLEN-1:0]   in_rs1, in_rs2, in_rs3;
  logic [TAGW-1:0]   in_tag;
  logic              in_ready, out_valid, out_illegal;
  logic [XLEN-1:0]   out_rs1, out_rs2, out_rs3;
  logic              out_insn3, out_insn5, out_insn12, out_insn13, out_insn14;
  logic              out_insn25, out_insn26, out_insn27, out_insn30;
  logic [TAGW-1:0]   out_tag;
  logic [15:0]       cnt_issued, cnt_illegal;

  logic              s_in_ready, s_out_valid, s_out_illegal;
  logic [31:0]       s_out_rs1, s_out_rs2, s_out_rs3;
  logic              s_i3, s_i5, s_i12, s_i13, s_i14, s_i25, s_i26, s_i27, s_i30;
  logic [TAGW-1:0]   s_out_tag;
  logic [15:0]       s_cnt_issued, s_cnt_illegal;

  rvb_issue #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_insn3(out_insn3), .out_insn5(out_insn5), .out_insn12(out_insn12),
    .out_insn13(out_insn13), .out_insn14(out_insn14), .out_insn25(out_insn25),
    .out_insn26(out_insn26), .out_insn27(out_insn27), .out_insn30(out_insn30),
    .out_tag(out_tag), .out_illegal(out_illegal),
    .cnt_issued(cnt_issued), .cnt_illegal(cnt_illegal)
  );

  // RV32 build driven in lockstep; used to confirm word forms are rejected.
  rvb_issue #(.XLEN(32), .TAGW(TAGW)) dut32 (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_insn(in_insn),
    .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]), .in_rs3(in_rs3[31:0]), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_rs3(s_out_rs3),
    .out_insn3(s_i3), .out_insn5(s_i5), .out_insn12(s_i12),
    .out_insn13(s_i13), .out_insn14(s_i14), .out_insn25(s_i25),
    .out_insn26(s_i26), .out_insn27(s_i27), .out_insn30(s_i30),
    .out_tag(s_out_tag), .out_illegal(s_out_illegal),
    .cnt_issued(s_cnt_issued), .cnt_illegal(s_cnt_illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] rs1, rs2, rs3;
    logic [8:0]  b;
    logic [3:0]  tag;
    logic        ill;
  } exp_t;

  localparam logic [8:0] OP_B [13] = '{
    9'b010110010, 9'b010110110, 9'b010111010, 9'b010111110, 9'b100011110,
    9'b100011010, 9'b100010010, 9'b010010010, 9'b010011110, 9'b110010010,
    9'b000000110, 9'b000001010, 9'b000001110};
  localparam logic [8:0] W_B [9] = '{
    9'b010010011, 9'b110010011, 9'b010100011, 9'b110100011, 9'b010000011,
    9'b110000011, 9'b000000111, 9'b000001011, 9'b000001111};

  exp_t q[$];
  int   exp_issued, exp_illegal;
  int   n_cmp, n_bad, n_pops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] insn, input logic [63:0] r1,
                                   input logic [63:0] r2, input logic [63:0] r3,
                                   input logic [3:0] tag);
    exp_t e;
    logic legal;
    logic upper_clear;
    e.b   = {insn[30], insn[27], insn[26], insn[25], insn[14], insn[13], insn[12], insn[5], insn[3]};
    e.rs1 = r1;
    e.rs2 = r2;
    e.rs3 = r3;
    e.tag = tag;
    upper_clear = (insn[31] == 1'b0) && (insn[29] == 1'b0) && (insn[28] == 1'b0);
    legal = 1'b0;
    if (insn[6:0] == 7'b0110011 && insn[26] == 1'b0 && upper_clear)
      for (int i = 0; i < 13; i++) if (OP_B[i] == e.b) legal = 1'b1;
    if (insn[6:0] == 7'b0110011 && insn[26] && insn[25] &&
        (insn[14:12] == 3'b001 || insn[14:12] == 3'b101))
      legal = 1'b1;
    if (insn[6:0] == 7'b0111011 && upper_clear)
      for (int i = 0; i < 9; i++) if (W_B[i] == e.b) legal = 1'b1;
    if (insn[6:0] == 7'b0011011 && insn[14:12] == 3'b100) begin
      legal = 1'b1;
      e.rs2 = {{52{insn[31]}}, insn[31:20]};
    end
    e.ill = !legal;
    return e;
  endfunction

  function automatic logic [31:0] put_b(input logic [31:0] w, input logic [8:0] b);
    logic [31:0] r;
    r = w;
    r[30] = b[8]; r[27] = b[7]; r[26] = b[6]; r[25] = b[5];
    r[14:12] = b[4:2]; r[5] = b[1]; r[3] = b[0];
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: begin
        w[6:0] = 7'b0110011;
        w = put_b(w, OP_B[$urandom_range(0, 12)]);
        w[31] = 1'b0; w[29] = 1'b0; w[28] = 1'b0;
      end
      1: begin
        w[6:0] = 7'b0111011;
        w = put_b(w, W_B[$urandom_range(0, 8)]);
        w[31] = 1'b0; w[29] = 1'b0; w[28] = 1'b0;
      end
      2: begin
        w[6:0] = 7'b0110011; w[26] = 1'b1; w[25] = 1'b1;
        w[14:12] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
      end
      3: begin
        w[6:0] = 7'b0011011; w[14:12] = 3'b100;
      end
      4: begin
        w[6:0] = 7'b0110011;
        w = put_b(w, OP_B[$urandom_range(0, 12)]);
        w[31] = 1'b0; w[29] = 1'b0; w[28] = 1'b0;
        w[$urandom_range(25, 31)] ^= 1'b1;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic set_rand_entry();
    in_insn = rand_insn();
    in_rs1  = {$urandom, $urandom};
    in_rs2  = {$urandom, $urandom};
    in_rs3  = {$urandom, $urandom};
    in_tag  = 4'($urandom);
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("cnt_issued", 64'(cnt_issued), 64'(exp_issued));
    chk("cnt_illegal", 64'(cnt_illegal), 64'(exp_illegal));
    if (q.size() != 0) begin
      chk("rs1", out_rs1, q[0].rs1);
      chk("rs2", out_rs2, q[0].rs2);
      chk("rs3", out_rs3, q[0].rs3);
      chk("bits", 64'({out_insn30, out_insn27, out_insn26, out_insn25, out_insn14,
                       out_insn13, out_insn12, out_insn5, out_insn3}), 64'(q[0].b));
      chk("tag", 64'(out_tag), 64'(q[0].tag));
      chk("illegal", 64'(out_illegal), 64'(q[0].ill));
    end
  endtask

  // One clock: predict the handshake from current inputs, advance, then compare.
  task automatic cycle();
    logic mpush, mpop;
    exp_t ne;
    mpush = in_valid && (q.size() < 2);
    mpop  = (q.size() != 0) && out_ready;
    ne    = predict(in_insn, in_rs1, in_rs2, in_rs3, in_tag);
    @(posedge clock);
    if (flush) begin
      q.delete();
    end else begin
      if (mpop) begin
        n_pops++;
        if (q[0].ill) exp_illegal = (exp_illegal == 65535) ? 65535 : exp_illegal + 1;
        else          exp_issued  = (exp_issued  == 65535) ? 65535 : exp_issued + 1;
        void'(q.pop_front());
      end
      if (mpush) q.push_back(ne);
    end
    #1;
    check_outputs();
  endtask

  int          guard;
  logic        acc;
  int          saved_iss, saved_ill;

  initial begin
    n_cmp = 0; n_bad = 0; n_pops = 0; exp_issued = 0; exp_illegal = 0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_insn = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_tag = '0;
    #23 resetn = 1'b1;
    @(posedge clock); #1;
    check_outputs();
    chk("rst_rs1", out_rs1, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);

    // MIN
    in_valid = 1'b1; out_ready = 1'b1; in_insn = 32'h0A20C1B3;
    in_rs1 = 64'd5; in_rs2 = -64'sd3; in_rs3 = 64'd0; in_tag = 4'd7;
    cycle();
    chk("min_valid", 64'(out_valid), 64'd1);
    chk("min_bits", 64'({out_insn30, out_insn27, out_insn26, out_insn25, out_insn14,
                         out_insn13, out_insn12, out_insn5, out_insn3}), 64'(9'b010110010));
    chk("min_ill", 64'(out_illegal), 64'd0);
    chk("min_tag", 64'(out_tag), 64'd7);
    in_valid = 1'b0;
    cycle();
    chk("min_cnt", 64'(cnt_issued), 64'd1);

    // ADDIWU
    in_valid = 1'b1; in_insn = 32'hFFF0C19B; in_rs2 = 64'h1234; in_tag = 4'd2;
    cycle();
    chk("addiwu_rs2", out_rs2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiwu_i5", 64'(out_insn5), 64'd0);
    chk("addiwu_i3", 64'(out_insn3), 64'd1);
    chk("addiwu_ill", 64'(out_illegal), 64'd0);
    chk("x32_valid", 64'(s_out_valid), 64'd1);
    chk("x32_ill", 64'(s_out_illegal), 64'd1);
    chk("x32_rs2", 64'(s_out_rs2), 64'h1234);
    in_valid = 1'b0;
    cycle();

    // ADDI nop is illegal here
    in_valid = 1'b1; in_insn = 32'h00000013; in_tag = 4'd3;
    cycle();
    chk("addi_ill", 64'(out_illegal), 64'd1);
    in_valid = 1'b0;
    cycle();
    chk("addi_cnt_ill", 64'(cnt_illegal), 64'd1);
    chk("addi_cnt_iss", 64'(cnt_issued), 64'd2);

    // Backpressure: two accepted, third held upstream.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; set_rand_entry(); in_tag = 4'(k + 1);
      cycle();
    end
    chk("bp_full", 64'(in_ready), 64'd0);
    set_rand_entry(); in_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_tag", 64'(out_tag), 64'd1);
    end
    out_ready = 1'b1;
    guard = 0;
    do begin
      acc = (q.size() < 2);
      cycle();
      guard++;
    end while (!acc && guard < 10);
    chk("bp_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      cycle();
      guard++;
    end
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Streaming 10 entries at full rate.
    n_pops = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; set_rand_entry();
      cycle();
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_pops", 64'(n_pops), 64'd10);

    // Flush with a concurrent push.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; set_rand_entry();
      cycle();
    end
    saved_iss = exp_issued; saved_ill = exp_illegal;
    flush = 1'b1; set_rand_entry();
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_cnt_iss", 64'(cnt_issued), 64'(saved_iss));
    chk("flush_cnt_ill", 64'(cnt_illegal), 64'(saved_ill));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      set_rand_entry();
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_rand_entry();
      cycle();
    end
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_cnt", 64'(cnt_issued), 64'd0);
    q.delete(); exp_issued = 0; exp_illegal = 0;
    in_valid = 1'b0;
    @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock); #1;
    check_outputs();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      set_rand_entry();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvb_issue.md
Name: rvb_issue

Overview:
Issue/decode stage directly upstream of the bit-manipulation ALU. Accepts a raw 32-bit instruction word plus operand values over valid/ready, then decodes and legality-checks it. For OP-IMM-32 it substitutes the sign-extended immediate for rs2. It buffers entries in a 2-entry registered FIFO and presents the ALU's operand and instruction-bit inputs with a tag and an illegal flag. It also keeps saturating issue/illegal statistics counters.

Parameters:
XLEN, 64, operand width (32 or 64); 64 enables the insn3=1 (word) forms.
TAGW, 4, width of the opaque tag carried alongside each instruction.

Ports:
clock  input  1  positive-edge clock
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; drops all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage accepts an entry (registered)
in_insn  input  32  raw instruction word
in_rs1  input  XLEN  rs1 value
in_rs2  input  XLEN  rs2 value
in_rs3  input  XLEN  rs3 value
in_tag  input  TAGW  opaque tag
out_valid  output  1  head entry valid
out_ready  input  1  ALU accepts the head entry
out_rs1  output  XLEN  rs1 value to the ALU
out_rs2  output  XLEN  rs2 value, or sext(insn[31:20]) for OP-IMM-32
out_rs3  output  XLEN  rs3 value to the ALU
out_insn3, out_insn5, out_insn12, out_insn13, out_insn14, out_insn25, out_insn26, out_insn27, out_insn30  output  1 each  decoded instruction bits
out_tag  output  TAGW  tag of the head entry
out_illegal  output  1  head entry is not a supported bit-manip op
cnt_issued  output  16  count of legal entries handed off
cnt_illegal  output  16  count of illegal entries handed off

Behaviour:
- Reset (resetn low, asynchronous): FIFO empty, out_valid=0, in_ready=1, cnt_*=0. All other outputs are don't-care while out_valid=0 but drive 0 after reset.
- FIFO: depth 2, fully registered. in_ready = !full, registered. Push = in_valid&&in_ready; pop = out_valid&&out_ready.
- Latency: entry pushed at edge N appears at out_* after edge N; out_valid is high in cycle N+1. Sustained throughput is 1 entry/cycle when out_ready=1.
- Simultaneous push+pop with 1 entry held: the count stays at 1 and the head becomes the new entry. Push while full is impossible because in_ready=0.
- Empty: out_valid=0, pop ignored. Full: in_ready=0 until the first pop edge.
- out_* fields are stable while out_valid&&!out_ready.
- flush: at the clock edge, entries clear, in_ready=1 next cycle, counters unchanged. A push in the same cycle is discarded. Flush has priority over push and pop.
- Decode at push time; decoded fields are stored, not the raw word. Let b = {i30,i27,i26,i25,i14,i13,i12,i5,i3}.
- Legal when any of the following holds:
  - opcode 0110011, i26=0, i31=i29=i28=0, and b in {010110010, 010110110, 010111010, 010111110, 100011110, 100011010, 100010010, 010010010, 010011110, 110010010, 000000110, 000001010, 000001110}.
  - opcode 0110011, i26=i25=1, funct3 in {001, 101} (CMIX/CMOV; bits 31:27 are rs3).
  - XLEN=64, opcode 0111011, i31=i29=i28=0, and b in {010010011, 110010011, 010100011, 110100011, 010000011, 110000011, 000000111, 000001011, 000001111}.
  - XLEN=64, opcode 0011011, funct3=100 (ADDIWU).
- Otherwise out_illegal=1, with bits and operands passed through unchanged.
- out_rs2 = sign-extend(in_insn[31:20]) to XLEN only for the legal ADDIWU form; otherwise out_rs2 = in_rs2.
- Counters increment at the pop edge: cnt_issued when !out_illegal, cnt_illegal when out_illegal. Both saturate at 0xFFFF.
- Reset mid-operation drops all entries immediately (asynchronously); no partial handshake completes.

Test Plan:
- Reset, then push insn 0x0A20C1B3 (MIN) with rs1=5, rs2=-3, tag=7, out_ready=1. Next cycle: out_valid=1, b=010110010, out_illegal=0, tag=7. cnt_issued=1 after the pop.
- Push 0xFFF0C19B (ADDIWU) with rs2=0x1234 -> out_rs2=0xFFFFFFFFFFFFFFFF, out_insn5=0, out_insn3=1, legal. With XLEN=32 the same word gives out_illegal=1.
- Push 0x00000013 (ADDI nop) -> out_illegal=1, cnt_illegal=1, cnt_issued unchanged.
- Hold out_ready=0 and push 3 back-to-back entries -> in_ready=0 after 2 accepted. The third is held upstream, outputs stay stable, and the order is preserved after out_ready=1.
- Streaming 10 entries with out_ready=1 -> 10 pops over 10 consecutive cycles, in_ready constantly 1.
- Two entries buffered; assert flush together with a push -> out_valid=0 and in_ready=1 the next cycle, counters unchanged. Then deassert resetn asynchronously mid-stream -> out_valid drops without a clock edge.
